// File: rtl/asip_pkg.sv
// Shared definitions for the multicycle ASIP core: opcodes, FSM state codes
// and a helper that derives the immediate width from the other field widths.
package asip_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_LD   = 4'd5,
    OP_ST   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_JMP  = 4'd8,
    OP_HALT = 4'd15
  } op_e;

  typedef logic [2:0] state_e;

  localparam state_e FETCH  = 3'd0;
  localparam state_e DECODE = 3'd1;
  localparam state_e EXEC   = 3'd2;
  localparam state_e MEM    = 3'd3;
  localparam state_e WB     = 3'd4;
  localparam state_e HALTED = 3'd5;

  function automatic int imm_width(input int data_w, input int op_w, input int ra_w);
    return data_w - op_w - 2 * ra_w;
  endfunction

endpackage

// File: rtl/asip_regfile.sv
// Register file: three combinational read ports, one synchronous write port,
// R0 hard-wired to zero, synchronous active-low clear.
module asip_regfile #(
  parameter  int DATA_W = 24,
  parameter  int NREGS  = 16,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra0,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NREGS];

  // NOTE: the array is built from flops, so clearing every entry on reset is
  // legal here; an SRAM-mapped array could not be reset this way.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd0 = (ra0 == '0) ? '0 : regs[ra0];
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/asip_multicycle_core.sv
// Multicycle ASIP core: FETCH/DECODE/EXEC/MEM/WB sequencing against
// req/ready instruction and data memories, with HALT and a stall counter.
module asip_multicycle_core
  import asip_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  localparam int RA_W  = $clog2(NREGS);
  localparam int IMM_W = imm_width(DATA_W, OP_W, RA_W);

  state_e            state;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_val, b_val, d_val, result;
  logic              st_op;

  logic [OP_W-1:0]   op;
  logic [RA_W-1:0]   rd_f, rs1_f, rs2_f;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] simm_d, alu;
  logic [ADDR_W-1:0] simm_a;
  logic [DATA_W-1:0] rf_a, rf_b, rf_d;

  assign op     = ir[DATA_W-1 -: OP_W];
  assign rd_f   = ir[DATA_W-OP_W-1 -: RA_W];
  assign rs1_f  = ir[DATA_W-OP_W-RA_W-1 -: RA_W];
  assign imm    = ir[IMM_W-1:0];
  assign rs2_f  = imm[IMM_W-1 -: RA_W];
  assign simm_d = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign simm_a = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};

  asip_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra0 (rs1_f),
    .ra1 (rs2_f),
    .ra2 (rd_f),
    .rd0 (rf_a),
    .rd1 (rf_b),
    .rd2 (rf_d),
    .we  (state == WB),
    .wa  (rd_f),
    .wd  (result)
  );

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    alu = a_val + simm_d;
    case (op)
      OP_W'(OP_ADD): alu = a_val + b_val;
      OP_W'(OP_SUB): alu = a_val - b_val;
      OP_W'(OP_AND): alu = a_val & b_val;
      OP_W'(OP_OR):  alu = a_val | b_val;
      default:       alu = a_val + simm_d;
    endcase
  end

  // Requests are masked while reset is held so nothing is issued before the first clean fetch.
  assign imem_req  = (state == FETCH) && rst;
  assign imem_addr = pc;
  assign dmem_req  = (state == MEM) && rst;
  assign dmem_we   = (state == MEM) && st_op && rst;
  assign halted    = (state == HALTED);

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= '0;
      a_val      <= '0;
      b_val      <= '0;
      d_val      <= '0;
      result     <= '0;
      st_op      <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            state <= DECODE;
          end else begin
            stall_cnt <= stall_cnt + {15'd0, ~&stall_cnt};
          end
        end
        DECODE: begin
          a_val <= rf_a;
          b_val <= rf_b;
          d_val <= rf_d;
          state <= EXEC;
        end
        EXEC: begin
          result <= alu;
          state  <= FETCH;
          case (op)
            OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR), OP_W'(OP_ADDI):
              state <= WB;
            OP_W'(OP_LD), OP_W'(OP_ST): begin
              dmem_addr  <= alu[ADDR_W-1:0];
              dmem_wdata <= d_val;
              st_op      <= (op == OP_W'(OP_ST));
              state      <= MEM;
            end
            OP_W'(OP_BEQ): pc <= (d_val == a_val) ? pc + 1'b1 + simm_a : pc + 1'b1;
            OP_W'(OP_JMP): pc <= ADDR_W'(imm);
            OP_W'(OP_HALT): state <= HALTED;
            default:       pc <= pc + 1'b1;
          endcase
        end
        MEM: begin
          if (dmem_ready) begin
            if (st_op) begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end else begin
              // Load data reuses the result register so WB has a single write source.
              result <= dmem_rdata;
              state  <= WB;
            end
          end else begin
            stall_cnt <= stall_cnt + {15'd0, ~&stall_cnt};
          end
        end
        WB: begin
          pc    <= pc + 1'b1;
          state <= FETCH;
        end
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_asip_multicycle_core.sv
// Self-checking bench for asip_multicycle_core: directed program steps, then
// random programs compared against an instruction-level reference model.
module tb_asip_multicycle_core;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 16;
  localparam int NBODY  = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req, imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [15:0]       stall_cnt;

  asip_multicycle_core dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [23:0] data;
  } wr_t;

  logic [23:0] imem [0:255];
  logic [23:0] dmem_m [int];
  wr_t         dut_wr[$];
  wr_t         mdl_wr[$];
  int          imem_lat, dmem_lat, icnt, dcnt;
  bit          unstable;
  logic [ADDR_W-1:0] cap_addr;
  logic [23:0] cap_data;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [23:0] mem_init(input int a);
    return 24'((a * 37) ^ 24'h5A5A5A);
  endfunction

  function automatic logic [23:0] enc(input int op, input int rd, input int rs1, input int imm);
    return {4'(op), 4'(rd), 4'(rs1), 12'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory responders: fixed wait states while requested, random ready while idle.
  initial begin
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    icnt = 0; dcnt = 0;
    forever begin
      @(negedge clk);
      imem_rdata = imem[imem_addr[7:0]];
      if (imem_req === 1'b1) begin
        if (icnt >= imem_lat) begin imem_ready = 1'b1; icnt = 0; end
        else begin imem_ready = 1'b0; icnt++; end
      end else begin
        imem_ready = 1'($urandom);
        icnt = 0;
      end
      if (dmem_req === 1'b1) begin
        if (dcnt == 0) begin cap_addr = dmem_addr; cap_data = dmem_wdata; end
        else if (dmem_addr !== cap_addr || dmem_wdata !== cap_data) unstable = 1'b1;
        if (dcnt >= dmem_lat) begin
          dmem_ready = 1'b1;
          dcnt = 0;
          if (dmem_we) begin
            dut_wr.push_back('{int'(dmem_addr), dmem_wdata});
            dmem_m[int'(dmem_addr)] = dmem_wdata;
            dmem_rdata = 24'($urandom);
          end else begin
            dmem_rdata = dmem_m.exists(int'(dmem_addr)) ? dmem_m[int'(dmem_addr)]
                                                        : mem_init(int'(dmem_addr));
          end
        end else begin
          dmem_ready = 1'b0;
          dcnt++;
          dmem_rdata = 24'($urandom);
        end
      end else begin
        dmem_ready = 1'($urandom);
        dmem_rdata = 24'($urandom);
        dcnt = 0;
      end
    end
  end

  initial begin
    logic [23:0] mr [16];
    logic [23:0] mm [int];
    logic [23:0] w, sx, v;
    int          mpc, m_cycles, m_stall, edges, bad, op, rd, rs1, rs2, imm, simm, a;
    bit          done;

    for (int i = 0; i < 256; i++) imem[i] = enc(15, 0, 0, 0);
    imem[0]  = enc(4, 1, 0, 5);
    imem[1]  = enc(4, 2, 0, -3);
    imem[2]  = enc(0, 3, 1, 2 << 8);
    imem[3]  = enc(6, 3, 0, 'h10);
    imem[4]  = enc(7, 1, 1, 2);
    imem[7]  = enc(7, 1, 2, 5);
    imem[8]  = enc(5, 4, 0, 'h10);
    imem[9]  = enc(4, 0, 0, 7);
    imem[10] = enc(6, 4, 0, 'h20);
    imem[11] = enc(6, 0, 0, 'h21);
    imem[12] = enc(15, 0, 0, 0);

    // Reset arriving in the middle of a stalled fetch.
    rst = 1'b0; imem_lat = 1000; dmem_lat = 0; unstable = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    check("stall_before_reset", stall_cnt, 3);
    rst = 1'b0;
    tick(3);
    check("rst_pc", pc, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 0);

    // Zero-wait ALU sequence: three instructions at 4 cycles each.
    imem_lat = 0;
    rst = 1'b1;
    tick(12);
    check("alu_seq_pc", pc, 3);
    check("alu_seq_fetch_addr", {imem_req, imem_addr}, {1'b1, 16'd3});

    // Store with four data wait states.
    dmem_lat = 4;
    tick(4);
    check("st_req_we", {dmem_req, dmem_we}, 2'b11);
    check("st_addr", dmem_addr, 'h10);
    check("st_wdata", dmem_wdata, 2);
    tick(3);
    check("st_no_early_write", dut_wr.size(), 0);
    tick(1);
    check("st_single_write", dut_wr.size(), 1);
    check("st_write_value", {dut_wr[0].addr[15:0], dut_wr[0].data}, {16'h10, 24'd2});
    check("st_pc", pc, 4);
    check("st_stall", stall_cnt, 4);
    check("st_stable", unstable, 0);

    tick(3);
    check("beq_taken_pc", pc, 7);
    tick(3);
    check("beq_not_taken_pc", pc, 8);

    dmem_m[16] = 24'hABCDEF;
    dmem_lat = 0;
    tick(5);
    check("ld_pc", pc, 9);
    tick(4);
    check("addi_r0_pc", pc, 10);
    tick(4);
    check("ld_value_stored", {dut_wr[$].addr[15:0], dut_wr[$].data}, {16'h20, 24'hABCDEF});
    tick(4);
    check("r0_stays_zero", {dut_wr[$].addr[15:0], dut_wr[$].data}, {16'h21, 24'h0});
    check("write_count", dut_wr.size(), 3);

    tick(2);
    check("halt_not_yet", halted, 0);
    tick(1);
    check("halted", halted, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    check("halted_quiet", bad, 0);
    check("halted_stall", stall_cnt, 4);
    rst = 1'b0;
    tick(1);
    check("rst_after_halt_req", imem_req, 0);
    rst = 1'b1;
    #1;
    check("restart_fetch", {imem_req, imem_addr, halted}, {1'b1, 16'd0, 1'b0});

    // Random programs against the instruction-level reference model.
    for (int r = 0; r < 6; r++) begin
      rst = 1'b0;
      tick(2);
      for (int i = 0; i < 256; i++) imem[i] = enc(15, 0, 0, 0);
      for (int i = 0; i < NBODY; i++) begin
        rd  = $urandom_range(0, 15);
        rs1 = $urandom_range(0, 15);
        imm = $urandom_range(0, 4095);
        case ($urandom_range(0, 11))
          0, 1, 2, 3: imem[i] = enc($urandom_range(0, 3), rd, rs1, imm);
          4, 5, 11:   imem[i] = enc(4, rd, rs1, imm);
          6:          imem[i] = enc(5, rd, rs1, imm);
          7:          imem[i] = enc(6, rd, rs1, imm);
          8: begin
            if ($urandom_range(0, 1) == 1) rs1 = rd;
            imm = $urandom_range(0, 3);
            if (imm > NBODY - 1 - i) imm = NBODY - 1 - i;
            imem[i] = enc(7, rd, rs1, imm);
          end
          9:       imem[i] = enc(8, 0, 0, $urandom_range(i + 1, NBODY));
          default: imem[i] = enc($urandom_range(9, 14), rd, rs1, imm);
        endcase
      end
      for (int i = 1; i < 16; i++) imem[NBODY + i - 1] = enc(6, i, 0, 'h100 + i);
      imem[NBODY + 15] = enc(15, 0, 0, 0);

      dmem_m.delete(); dut_wr.delete(); mdl_wr.delete(); mm.delete();
      unstable = 1'b0;
      imem_lat = $urandom_range(0, 2);
      dmem_lat = $urandom_range(0, 3);

      for (int i = 0; i < 16; i++) mr[i] = '0;
      mpc = 0; m_cycles = 0; m_stall = 0; done = 1'b0;
      for (int n = 0; n < 500 && !done; n++) begin
        w    = imem[mpc[7:0]];
        op   = int'(w[23:20]);
        rd   = int'(w[19:16]);
        rs1  = int'(w[15:12]);
        rs2  = int'(w[11:8]);
        imm  = int'(w[11:0]);
        simm = (imm >= 2048) ? imm - 4096 : imm;
        sx   = 24'(simm);
        a    = int'(16'(mr[rs1] + sx));
        m_cycles += imem_lat;
        m_stall  += imem_lat;
        case (op)
          0, 1, 2, 3, 4: begin
            if (op == 0)      mr[rd] = mr[rs1] + mr[rs2];
            else if (op == 1) mr[rd] = mr[rs1] - mr[rs2];
            else if (op == 2) mr[rd] = mr[rs1] & mr[rs2];
            else if (op == 3) mr[rd] = mr[rs1] | mr[rs2];
            else              mr[rd] = mr[rs1] + sx;
            m_cycles += 4; mpc += 1;
          end
          5: begin
            v = mm.exists(a) ? mm[a] : mem_init(a);
            mr[rd] = v;
            m_cycles += 5 + dmem_lat; m_stall += dmem_lat; mpc += 1;
          end
          6: begin
            mm[a] = mr[rd];
            mdl_wr.push_back('{a, mr[rd]});
            m_cycles += 4 + dmem_lat; m_stall += dmem_lat; mpc += 1;
          end
          7: begin
            mpc = (mr[rd] == mr[rs1]) ? mpc + 1 + simm : mpc + 1;
            m_cycles += 3;
          end
          8: begin mpc = imm; m_cycles += 3; end
          15: begin m_cycles += 3; done = 1'b1; end
          default: begin m_cycles += 3; mpc += 1; end
        endcase
        mr[0] = '0;
        mpc = mpc & 'hFFFF;
      end
      if (m_stall > 65535) m_stall = 65535;

      rst = 1'b1;
      edges = 0;
      while (halted !== 1'b1 && edges < 4000) begin
        tick(1);
        edges++;
      end
      check($sformatf("rand%0d_cycles", r), edges, m_cycles);
      check($sformatf("rand%0d_stall", r), stall_cnt, m_stall);
      check($sformatf("rand%0d_stable", r), unstable, 0);
      check($sformatf("rand%0d_writes", r), dut_wr.size(), mdl_wr.size());
      for (int i = 0; i < dut_wr.size() && i < mdl_wr.size(); i++)
        check($sformatf("rand%0d_wr%0d", r, i), {dut_wr[i].addr[7:0], dut_wr[i].data},
              {mdl_wr[i].addr[7:0], mdl_wr[i].data});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
